pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the Write and

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes,
// data-memory wait freezing with timeout into a sticky error state.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memToR,
    input  logic [4:0]       ex_gprDes,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Bit order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, memwb_f
    localparam logic [7:0] CTRL_RST    = 8'b0010_1001;
    localparam logic [7:0] CTRL_FREEZE = 8'b0000_0000;
    localparam logic [7:0] CTRL_NORM   = 8'b1101_0110;
    localparam logic [7:0] CTRL_BR     = 8'b1111_1110;
    localparam logic [7:0] CTRL_LU     = 8'b0001_1110;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             load_use;
    logic [7:0]       run_ctrl;
    logic [7:0]       ctrl;

    always_comb begin
        load_use = ex_memToR && (ex_gprDes != 5'd0) &&
                   ((ex_gprDes == id_rs) || (id_uses_rt && (ex_gprDes == id_rt)));
        // A taken branch squashes the ID instruction, so its load-use hazard is moot.
        if (br_taken) begin
            run_ctrl = CTRL_BR;
        end else if (load_use) begin
            run_ctrl = CTRL_LU;
        end else begin
            run_ctrl = CTRL_NORM;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        ctrl       = CTRL_FREEZE;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    wait_cnt_d = WC_W'(1);
                    state_d    = MEM_WAIT;
                end else begin
                    ctrl = run_ctrl;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl       = run_ctrl;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!rst) begin
            ctrl = CTRL_RST;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl[7] && (state_q != ERR) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign pc_write    = ctrl[7];
    assign ifid_write  = ctrl[6];
    assign ifid_flush  = ctrl[5];
    assign idex_write  = ctrl[4];
    assign idex_flush  = ctrl[3];
    assign exmem_write = ctrl[2];
    assign memwb_write = ctrl[1];
    assign memwb_flush = ctrl[0];
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] C_RST = 8'b0010_1001;
    localparam logic [7:0] C_FRZ = 8'b0000_0000;
    localparam logic [7:0] C_NRM = 8'b1101_0110;
    localparam logic [7:0] C_BR  = 8'b1111_1110;
    localparam logic [7:0] C_LU  = 8'b0001_1110;

    typedef struct {
        logic [7:0]  ctrl;
        logic        err;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_gprDes = '0;
    logic        id_uses_rt = 1'b0, ex_memToR = 1'b0, br_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic        exmem_write, memwb_write, memwb_flush, mem_err;
    logic [15:0] stall_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush;
    logic        s_exmem_write, s_memwb_write, s_memwb_flush, s_mem_err;
    logic [3:0]  s_stall_cnt;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_cnt_s = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memToR(ex_memToR), .ex_gprDes(ex_gprDes), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_write(memwb_write), .memwb_flush(memwb_flush), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) u_dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memToR(ex_memToR), .ex_gprDes(ex_gprDes), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_write(s_idex_write), .idex_flush(s_idex_flush), .exmem_write(s_exmem_write),
        .memwb_write(s_memwb_write), .memwb_flush(s_memwb_flush), .mem_err(s_mem_err),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check_out(input string tag);
        exp_t       e;
        logic [7:0] got;
        logic [7:0] got_s;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got 0 entries want 1", tag);
            return;
        end
        e     = sb.pop_front();
        got   = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, memwb_write, memwb_flush};
        got_s = {s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush,
                 s_exmem_write, s_memwb_write, s_memwb_flush};
        total++;
        assert (got === e.ctrl) else begin
            bad++;
            $error("FAIL %s ctrl got %b want %b", tag, got, e.ctrl);
        end
        total++;
        assert (got_s === e.ctrl) else begin
            bad++;
            $error("FAIL %s ctrl_small got %b want %b", tag, got_s, e.ctrl);
        end
        total++;
        assert (mem_err === e.err) else begin
            bad++;
            $error("FAIL %s mem_err got %b want %b", tag, mem_err, e.err);
        end
        total++;
        assert (stall_cnt === e.cnt) else begin
            bad++;
            $error("FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, e.cnt);
        end
        total++;
        assert (s_stall_cnt === e.cnt_s) else begin
            bad++;
            $error("FAIL %s stall_cnt_small got %0d want %0d", tag, s_stall_cnt, e.cnt_s);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs 1 ns later.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic ld, input logic [4:0] des, input logic br,
                        input logic rq, input logic rd, input logic [7:0] ec,
                        input logic ee, input string tag);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memToR = ld; ex_gprDes = des;
        br_taken = br; mem_req = rq; mem_ready = rd;
        sb.push_back('{ctrl: ec, err: ee, cnt: m_cnt, cnt_s: m_cnt_s});
        #1;
        check_out(tag);
        if (!ec[7] && !ee) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memToR = 1'b0; ex_gprDes = '0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        m_cnt = '0;
        m_cnt_s = '0;
        sb.push_back('{ctrl: C_RST, err: 1'b0, cnt: 16'd0, cnt_s: 4'd0});
        #1;
        check_out(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then quiet pipe
        do_reset("rst0");
        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "norm0");
        step(5'd3, 5'd4, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "norm1");

        // 2: load-use on rs, then on rt, and rt ignored when not a source
        step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, "lu_rs");
        step(5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "lu_after");
        step(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, "lu_rt");
        step(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "lu_rt_unused");
        step(5'd3, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "lu_nomatch");

        // 3: branch overrides load-use; r0 never stalls
        step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_BR,  1'b0, "br_over_lu");
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "lu_r0");

        // 4: three wait cycles, then ready; ready without request is ignored
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw0");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw1");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw2");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NRM, 1'b0, "mw_rdy");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NRM, 1'b0, "rdy_noreq");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw_br0");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR,  1'b0, "mw_br_rdy");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "mw_back");

        // 5: timeout after MEM_TIMEOUT+1 frozen cycles, ERR ignores inputs
        for (int i = 0; i < 16; i++) begin
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "to_wait");
        end
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b1, "err0");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_FRZ, 1'b1, "err_br_rdy");
        step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1, "err_lu");
        do_reset("rst_err");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "post_err");

        // reset in the middle of a memory wait
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw_rst0");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, "mw_rst1");
        do_reset("rst_mw");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NRM, 1'b0, "post_mw");

        // 6: 20 consecutive stalls; the 4-bit counter holds at 15
        for (int i = 0; i < 20; i++) begin
            step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, "sat");
        end
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NRM, 1'b0, "sat_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
